sram_port_arbiter: RTL and testbench

- Shares the single-port on-chip SRAM (1024 x 32, byte-enabled, one-cycle registered-address read) between two Avalon-MM masters, m0 and m1. Typical pairing: m0 is the Nios II data master, m1 is a DMA or debug master.
- Grants at most one transfer per clock using round-robin, drives the SRAM slave port, and routes read data back to the master that issued the read.
- Holds off all grants while the SRAM's reset_req is asserted.

---
 rtl/sram_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port 1024x32 byte-enabled SRAM (one-cycle registered
//   address read) between two Avalon-MM masters, m0 and m1. At most one
//   transfer is granted per clock. Read data is routed back to the master
//   that issued the read, two cycles after the request cycle.
//
//   Optional build macro:
//     SRAM_ARB_FIXED_PRIORITY_EN - m0 always wins a conflict. When it is
//     undefined (default), conflicts are resolved round-robin.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   reset_req           SRAM reset request; no grants while high
//   m0_* / m1_*         Avalon-MM slave side for each master
//                       (address, byteenable, read, write, writedata in;
//                        waitrequest, readdata, readdatavalid out)
//   ram_*               SRAM slave port drive (address, byteenable,
//                       chipselect, write, writedata, clken out; readdata in)
module sram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  logic              req0, req1;
  logic              grant_ok;
  logic              gnt0, gnt1;
  logic              rd_accept;
  owner_e            rd_owner;

  logic              s1_valid;
  owner_e            s1_owner;
  logic [DATA_W-1:0] rdata_q;

  assign req0     = m0_read | m0_write;
  assign req1     = m1_read | m1_write;
  assign grant_ok = ~reset & ~reset_req;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt0 = grant_ok & req0;
    gnt1 = grant_ok & req1 & ~req0;
  end
`else
  owner_e last_gnt;

  // On a conflict the master that did not win most recently is served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (grant_ok) begin
      if (req0 && req1) begin
        gnt0 = (last_gnt == OWN_M1);
        gnt1 = (last_gnt == OWN_M0);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= OWN_M1;
    end else if (gnt0) begin
      last_gnt <= OWN_M0;
    end else if (gnt1) begin
      last_gnt <= OWN_M1;
    end
  end
`endif

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Address/byteenable/writedata default to m0 so they only toggle
  // when m1 actually owns the port.
  always_comb begin
    ram_address    = m0_address;
    ram_byteenable = m0_byteenable;
    ram_writedata  = m0_writedata;
    if (gnt1) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end
  end

  assign ram_chipselect = gnt0 | gnt1;
  assign ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);

  // A simultaneous read+write is treated as a write only.
  assign rd_accept = (gnt0 & m0_read & ~m0_write) | (gnt1 & m1_read & ~m1_write);
  assign rd_owner  = gnt1 ? OWN_M1 : OWN_M0;

  // Stage 1 marks the edge the SRAM captured the address; stage 2 captures
  // the SRAM output and raises the owner's readdatavalid for one cycle.
  // The pipeline keeps advancing during reset_req so accepted reads finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_clken        <= 1'b0;
      s1_valid         <= 1'b0;
      s1_owner         <= OWN_M0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      rdata_q          <= '0;
    end else begin
      ram_clken        <= 1'b1;
      s1_valid         <= rd_accept;
      s1_owner         <= rd_owner;
      m0_readdatavalid <= s1_valid & (s1_owner == OWN_M0);
      m1_readdatavalid <= s1_valid & (s1_owner == OWN_M1);
      if (s1_valid) begin
        rdata_q <= ram_readdata;
      end
    end
  end

  assign m0_readdata = rdata_q;
  assign m1_readdata = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        reset_req;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;

  int n_vec;
  int n_err;

  // SRAM the arbiter drives (environment, not the checker)
  logic [31:0] sram [0:1023] = '{default: '0};
  // Reference contents seen by the random-traffic model
  logic [31:0] ref_mem [0:1023] = '{default: '0};

  typedef struct {
    int          due;
    int          owner;
    logic [31:0] data;
  } resp_t;
  resp_t exp_q[$];

  sram_port_arbiter #(
    .ADDR_W(10),
    .DATA_W(32),
    .BE_W(4)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) sram[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= sram[ram_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 1'b0; m0_write = 1'b0;
    m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_req = 1'b0;
    idle();
    m0_read = 1'b1; m1_write = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_vec++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
    n_vec++; if (m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
    n_vec++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL reset_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    n_vec++; if (m0_readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", m0_readdata); end
    n_vec++; if (ram_chipselect !== 1'b0 || ram_write !== 1'b0) begin n_err++; $display("FAIL reset_ram_cs_wr: got %b%b want 00", ram_chipselect, ram_write); end
    n_vec++; if (ram_clken !== 1'b0) begin n_err++; $display("FAIL reset_clken: got %b want 0", ram_clken); end
    tick();
    idle();
    reset = 1'b0;
    tick();
    @(negedge clk);
    n_vec++; if (ram_clken !== 1'b1) begin n_err++; $display("FAIL post_reset_clken: got %b want 1", ram_clken); end
    n_vec++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL idle_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    tick();
  endtask

  task automatic test_single_write();
    idle();
    m0_write = 1'b1; m0_address = 10'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    @(negedge clk);
    n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL wr_m0_wait: got %b want 0", m0_waitrequest); end
    n_vec++; if (ram_write !== 1'b1 || ram_chipselect !== 1'b1) begin n_err++; $display("FAIL wr_ram_wr_cs: got %b%b want 11", ram_write, ram_chipselect); end
    n_vec++; if (ram_address !== 10'h005) begin n_err++; $display("FAIL wr_ram_addr: got %h want 005", ram_address); end
    n_vec++; if (ram_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_data: got %h want deadbeef", ram_writedata); end
    tick();
  endtask

  task automatic test_readback();
    idle();
    m0_read = 1'b1; m0_address = 10'h005;
    @(negedge clk);
    n_vec++; if (m0_waitrequest !== 1'b0 || ram_write !== 1'b0) begin n_err++; $display("FAIL rb_accept: wait/ram_write got %b%b want 00", m0_waitrequest, ram_write); end
    tick();
    idle();
    @(negedge clk);
    n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rb_early_rdv: got %b want 0", m0_readdatavalid); end
    tick();
    @(negedge clk);
    n_vec++; if (m0_readdatavalid !== 1'b1) begin n_err++; $display("FAIL rb_rdv: got %b want 1", m0_readdatavalid); end
    n_vec++; if (m0_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rb_data: got %h want deadbeef", m0_readdata); end
    n_vec++; if (m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rb_m1_rdv: got %b want 0", m1_readdatavalid); end
    tick();
    @(negedge clk);
    n_vec++; if (m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rb_rdv_len: got %b want 0", m0_readdatavalid); end
    tick();
  endtask

  task automatic test_byte_lane();
    idle();
    m1_write = 1'b1; m1_address = 10'h005; m1_writedata = 32'h0000AA00; m1_byteenable = 4'h2;
    @(negedge clk);
    n_vec++; if (m1_waitrequest !== 1'b0 || ram_byteenable !== 4'h2) begin n_err++; $display("FAIL bl_wr: wait=%b be=%h want 0/2", m1_waitrequest, ram_byteenable); end
    tick();
    idle();
    m1_read = 1'b1;
    tick();
    idle();
    tick();
    @(negedge clk);
    n_vec++; if (m1_readdatavalid !== 1'b1 || m0_readdatavalid !== 1'b0) begin n_err++; $display("FAIL bl_rdv: got m0=%b m1=%b want 0/1", m0_readdatavalid, m1_readdatavalid); end
    n_vec++; if (m1_readdata !== 32'hDEADAAEF) begin n_err++; $display("FAIL bl_data: got %h want deadaaef", m1_readdata); end
    tick();
  endtask

  task automatic test_conflict();
    int order[4];
    int g, o;
    logic [31:0] exp_d;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    order = '{0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1};
`endif
    // preload; the m1 write last leaves m1 as most recent winner
    idle();
    m0_write = 1'b1; m0_address = 10'h010; m0_writedata = 32'h11111111; m0_byteenable = 4'hF;
    tick();
    idle();
    m1_write = 1'b1; m1_address = 10'h020; m1_writedata = 32'h22222222; m1_byteenable = 4'hF;
    tick();
    idle();
    m0_address = 10'h010; m1_address = 10'h020;
    for (int c = 0; c < 6; c++) begin
      m0_read = (c < 4); m1_read = (c < 4);
      g = (c < 4) ? order[c] : -1;
      @(negedge clk);
      n_vec++; if (m0_waitrequest !== (g != 0) || m1_waitrequest !== (g != 1)) begin n_err++; $display("FAIL cf_grant c=%0d: wait m0/m1 got %b%b want %b%b", c, m0_waitrequest, m1_waitrequest, g != 0, g != 1); end
      o = (c >= 2) ? order[c-2] : -1;
      n_vec++; if (m0_readdatavalid !== (o == 0) || m1_readdatavalid !== (o == 1)) begin n_err++; $display("FAIL cf_rdv c=%0d: got %b%b want %b%b", c, m0_readdatavalid, m1_readdatavalid, o == 0, o == 1); end
      if (o >= 0) begin
        exp_d = (o == 0) ? 32'h11111111 : 32'h22222222;
        n_vec++; if (m0_readdata !== exp_d) begin n_err++; $display("FAIL cf_data c=%0d: got %h want %h", c, m0_readdata, exp_d); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_holdoff();
    idle();
    m1_read = 1'b1; m1_address = 10'h020;
    @(negedge clk);
    n_vec++; if (m1_waitrequest !== 1'b0) begin n_err++; $display("FAIL ho_m1_accept: got %b want 0", m1_waitrequest); end
    tick();
    idle();
    m0_address = 10'h010;
    for (int c = 1; c < 7; c++) begin
      reset_req = (c <= 3);
      m0_read = (c <= 4);
      @(negedge clk);
      if (c <= 3) begin
        n_vec++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL ho_wait c=%0d: got %b%b want 11", c, m0_waitrequest, m1_waitrequest); end
      end
      if (c == 4) begin
        n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL ho_m0_grant: got %b want 0", m0_waitrequest); end
      end
      n_vec++; if (m1_readdatavalid !== (c == 2) || m0_readdatavalid !== (c == 6)) begin n_err++; $display("FAIL ho_rdv c=%0d: m0/m1 got %b%b", c, m0_readdatavalid, m1_readdatavalid); end
      if (c == 2) begin
        n_vec++; if (m1_readdata !== 32'h22222222) begin n_err++; $display("FAIL ho_m1_data: got %h want 22222222", m1_readdata); end
      end
      if (c == 6) begin
        n_vec++; if (m0_readdata !== 32'h11111111) begin n_err++; $display("FAIL ho_m0_data: got %h want 11111111", m0_readdata); end
      end
      tick();
    end
    reset_req = 1'b0;
    idle();
  endtask

  task automatic test_reset_drop();
    idle();
    m0_read = 1'b1; m0_address = 10'h010; m1_address = 10'h020;
    @(negedge clk);
    n_vec++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_accept: got %b want 0", m0_waitrequest); end
    tick();
    idle();
    reset = 1'b1;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      n_vec++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin n_err++; $display("FAIL rd_dropped c=%0d: got %b%b want 00", c, m0_readdatavalid, m1_readdatavalid); end
      tick();
      reset = 1'b0;
    end
    m0_read = 1'b1; m1_read = 1'b1;
    @(negedge clk);
    n_vec++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin n_err++; $display("FAIL rd_conflict: wait got %b%b want 01", m0_waitrequest, m1_waitrequest); end
    tick();
    idle();
    tick();
    @(negedge clk);
    n_vec++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h11111111) begin n_err++; $display("FAIL rd_after_reset: rdv=%b data=%h want 1/11111111", m0_readdatavalid, m0_readdata); end
    tick();
  endtask

  task automatic test_random();
    int last, win;
    logic w0, w1, rd0, rd1;
    logic [9:0] a;
    logic [3:0] be;
    logic [31:0] wd;
    logic e0, e1;
    logic [31:0] ed;
    exp_q.delete();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    last = 1;
    for (int t = 0; t < 304; t++) begin
      if (t < 300) begin
        reset_req = ($urandom_range(0, 7) == 0);
        m0_read = $urandom_range(0, 1); m0_write = ($urandom_range(0, 3) == 0);
        m1_read = $urandom_range(0, 1); m1_write = ($urandom_range(0, 3) == 0);
        m0_address = 10'h200 + 10'($urandom_range(0, 15));
        m1_address = 10'h200 + 10'($urandom_range(0, 15));
        m0_byteenable = 4'($urandom); m1_byteenable = 4'($urandom);
        m0_writedata = $urandom; m1_writedata = $urandom;
      end else begin
        reset_req = 1'b0;
        idle();
      end
      w0 = m0_write; w1 = m1_write;
      rd0 = m0_read; rd1 = m1_read;
      win = -1;
      if (!reset_req) begin
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        if (w0 || rd0) win = 0;
        else if (w1 || rd1) win = 1;
`else
        if ((w0 || rd0) && (w1 || rd1)) win = 1 - last;
        else if (w0 || rd0) win = 0;
        else if (w1 || rd1) win = 1;
`endif
      end
      e0 = 1'b0; e1 = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].due == t) begin
        e0 = (exp_q[0].owner == 0);
        e1 = (exp_q[0].owner == 1);
        ed = exp_q[0].data;
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      n_vec++; if (m0_waitrequest !== (win != 0) || m1_waitrequest !== (win != 1)) begin n_err++; $display("FAIL rnd_grant t=%0d: wait got %b%b want %b%b", t, m0_waitrequest, m1_waitrequest, win != 0, win != 1); end
      n_vec++; if (ram_chipselect !== (win >= 0) || ram_write !== ((win == 0 && w0) || (win == 1 && w1))) begin n_err++; $display("FAIL rnd_ram_ctl t=%0d: cs/wr got %b%b", t, ram_chipselect, ram_write); end
      if (win >= 0) begin
        a = (win == 0) ? m0_address : m1_address;
        n_vec++; if (ram_address !== a) begin n_err++; $display("FAIL rnd_ram_addr t=%0d: got %h want %h", t, ram_address, a); end
      end
      n_vec++; if (m0_readdatavalid !== e0 || m1_readdatavalid !== e1) begin n_err++; $display("FAIL rnd_rdv t=%0d: got %b%b want %b%b", t, m0_readdatavalid, m1_readdatavalid, e0, e1); end
      if (e0 || e1) begin
        n_vec++; if (m0_readdata !== ed || m1_readdata !== ed) begin n_err++; $display("FAIL rnd_data t=%0d: got %h want %h", t, m0_readdata, ed); end
      end
      @(posedge clk);
      if (win >= 0) begin
        last = win;
        a  = (win == 0) ? m0_address : m1_address;
        be = (win == 0) ? m0_byteenable : m1_byteenable;
        wd = (win == 0) ? m0_writedata : m1_writedata;
        if ((win == 0) ? w0 : w1) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
          exp_q.push_back('{due: t + 2, owner: win, data: ref_mem[a]});
        end
      end
      #1;
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain: %0d responses outstanding, want 0", exp_q.size()); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    reset_req = 1'b0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    idle();
    test_reset();
    test_single_write();
    test_readback();
    test_byte_lane();
    test_conflict();
    test_holdoff();
    test_reset_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
